// File: rtl/board_store.sv
// Dark-chess board register: loads the canonical 32-piece set on start, shuffles it
// with an LFSR-driven Fisher-Yates pass, then serves single-square writes.
module board_store #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         shuffle_start,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [4:0]   wr_piece,
    output logic [159:0] board_output,
    output logic         board_ready,
    output logic [4:0]   red_alive,
    output logic [4:0]   black_alive
);

    localparam int unsigned NSQ = 32;
    localparam int unsigned PW  = 5;
    localparam int unsigned IW  = 5;
    localparam int unsigned RW  = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHUFFLE = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   board     [NSQ];
    logic [PW-1:0]   board_nxt [NSQ];
    logic [15:0]     lfsr, lfsr_nxt;
    logic [IW-1:0]   step_i, step_i_nxt;
    logic [RW-1:0]   retry, retry_nxt;
    logic [IW-1:0]   draw_j;
    logic            load_c, swap_c, write_c;
    logic [4:0]      red_cnt_c, black_cnt_c;

    // Canonical covered layout; colour is the upper index bit.
    function automatic logic [PW-1:0] canon_piece(input logic [IW-1:0] idx);
        logic [2:0] ptype;
        case (idx[3:0])
            4'd0:        ptype = 3'b111;
            4'd1, 4'd2:  ptype = 3'b110;
            4'd3, 4'd4:  ptype = 3'b101;
            4'd5, 4'd6:  ptype = 3'b100;
            4'd7, 4'd8:  ptype = 3'b011;
            4'd9, 4'd10: ptype = 3'b010;
            default:     ptype = 3'b001;
        endcase
        return {idx[4], ptype, 1'b0};
    endfunction

    // Free-running Galois LFSR, shift right.
    always_comb begin
        lfsr_nxt = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_nxt = (lfsr >> 1) ^ LFSR_TAPS;
        end
    end

    assign draw_j = lfsr[IW-1:0];

    // Next-state and board update decode.
    always_comb begin
        state_nxt  = state;
        step_i_nxt = step_i;
        retry_nxt  = retry;
        load_c     = 1'b0;
        swap_c     = 1'b0;
        write_c    = 1'b0;
        case (state)
            IDLE: begin
                if (shuffle_start) begin
                    state_nxt  = SHUFFLE;
                    step_i_nxt = IW'(NSQ - 1);
                    retry_nxt  = '0;
                end
            end
            SHUFFLE: begin
                if (draw_j <= step_i) begin
                    swap_c     = 1'b1;
                    step_i_nxt = step_i - IW'(1);
                    retry_nxt  = '0;
                    if (step_i == IW'(1)) begin
                        state_nxt = READY;
                    end
                end else if (retry == RW'(MAX_RETRY - 1)) begin
                    step_i_nxt = step_i - IW'(1);
                    retry_nxt  = '0;
                    if (step_i == IW'(1)) begin
                        state_nxt = READY;
                    end
                end else begin
                    retry_nxt = retry + RW'(1);
                end
            end
            READY: begin
                if (shuffle_start) begin
                    load_c     = 1'b1;
                    state_nxt  = SHUFFLE;
                    step_i_nxt = IW'(NSQ - 1);
                    retry_nxt  = '0;
                end else if (wr_en) begin
                    write_c = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-square next value; i takes board[j] first so j==i degenerates to a hold.
    always_comb begin
        for (int unsigned k = 0; k < NSQ; k++) begin
            board_nxt[k] = board[k];
            if (load_c) begin
                board_nxt[k] = canon_piece(IW'(k));
            end else if (swap_c && (IW'(k) == step_i)) begin
                board_nxt[k] = board[draw_j];
            end else if (swap_c && (IW'(k) == draw_j)) begin
                board_nxt[k] = board[step_i];
            end else if (write_c && (IW'(k) == wr_addr)) begin
                board_nxt[k] = wr_piece;
            end
        end
    end

    // Live-piece popcount of the current board.
    always_comb begin
        red_cnt_c   = '0;
        black_cnt_c = '0;
        for (int unsigned k = 0; k < NSQ; k++) begin
            if (board[k][3:1] != 3'b000) begin
                if (board[k][4]) begin
                    black_cnt_c = black_cnt_c + 5'd1;
                end else begin
                    red_cnt_c = red_cnt_c + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            lfsr        <= SEED_EFF;
            step_i      <= IW'(NSQ - 1);
            retry       <= '0;
            board_ready <= 1'b0;
            red_alive   <= 5'd16;
            black_alive <= 5'd16;
            for (int unsigned k = 0; k < NSQ; k++) begin
                board[k] <= canon_piece(IW'(k));
            end
        end else begin
            state       <= state_nxt;
            lfsr        <= lfsr_nxt;
            step_i      <= step_i_nxt;
            retry       <= retry_nxt;
            board_ready <= (state_nxt == READY);
            red_alive   <= red_cnt_c;
            black_alive <= black_cnt_c;
            for (int unsigned k = 0; k < NSQ; k++) begin
                board[k] <= board_nxt[k];
            end
        end
    end

    for (genvar g = 0; g < NSQ; g++) begin : g_flat
        assign board_output[g*PW +: PW] = board[g];
    end

endmodule
